sprw_driver: RTL and testbench

SPRW_DRIVER -- requirements
Module: sprw_driver

---
 rtl/sprw_driver_pkg.sv | 25 ++
 rtl/sprw_result_fifo.sv | 70 +++++++
 rtl/sprw_driver.sv | 109 ++++++++++
 tb/tb_sprw_driver.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sprw_driver_pkg.sv
// Shared constants and types for the SPARROW pipeline driver.
// No logic: defaults for pipeline latency and result buffer depth, operation bundle.
// Imported by sprw_driver and sprw_result_fifo.
package sprw_driver_pkg;

  // Default cycles from operands on sprw_* to a sampled sprw_result
  localparam int SPRW_LAT   = 2;
  // Default result buffer entries, which is also the outstanding-operation limit
  localparam int SPRW_DEPTH = 4;
  // Data path width of the SPARROW interface
  localparam int SPRW_W     = 32;

  // One operation as driven into the SPARROW pipeline
  typedef struct packed {
    logic [SPRW_W-1:0] ra;
    logic [SPRW_W-1:0] rb;
    logic [SPRW_W-1:0] instr;
  } sprw_op_t;

  // Bits needed to hold a count in the range 0..n inclusive
  function automatic int sprw_cnt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/sprw_result_fifo.sv
// Purpose: first-in first-out buffer for SPARROW results, head shown combinationally.
// Latency: a push is visible at o_head_dat the cycle after the push edge.
// Backpressure: none internally; the driver's credit count keeps pushes off a full buffer.
module sprw_result_fifo
  import sprw_driver_pkg::*;
#(
  parameter int DEPTH = SPRW_DEPTH,
  parameter int W     = SPRW_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  logic [W-1:0] i_push_dat,
  input  logic         i_pop,
  output logic [W-1:0] o_head_dat,
  output logic         o_full,
  output logic         o_empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = sprw_cnt_w(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_do_push;
  logic          w_do_pop;

  // Pointers wrap explicitly so DEPTH need not be a power of two
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // A pop on an empty buffer is ignored; a push on a full buffer only lands if a pop frees the slot
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);

  assign o_full     = (r_count == CW'(DEPTH));
  assign o_empty    = (r_count == '0);
  assign o_head_dat = r_mem[r_rd_ptr];

  // Storage array, no reset needed since reads are qualified by o_empty
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_push_dat;
    end
  end

  // Pointer and occupancy update; push+pop together leaves occupancy unchanged
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_do_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // The driver never pops an empty buffer
  a_no_underflow: assert property (@(posedge clk) disable iff (rst) !(i_pop && o_empty));

endmodule

// File: rtl/sprw_driver.sv
// Purpose: feeds host operations into the fixed-latency SPARROW pipeline and buffers results.
// Latency: accept at edge t, result capture at edge t+LAT, out_valid seen from edge t+LAT+1.
// Backpressure: in_ready drops when in-flight plus buffered operations reach DEPTH; pipeline never stalls.
module sprw_driver
  import sprw_driver_pkg::*;
#(
  parameter int LAT   = SPRW_LAT,
  parameter int DEPTH = SPRW_DEPTH
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_ra,
  input  logic [31:0] in_rb,
  input  logic [31:0] in_instr,
  output logic [31:0] sprw_ra,
  output logic [31:0] sprw_rb,
  output logic [31:0] sprw_instr,
  output logic        sprw_holdn,
  input  logic [31:0] sprw_result,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic        busy
);

  localparam int CW = sprw_cnt_w(DEPTH);

  sprw_op_t      r_op;
  logic [LAT-1:0] r_vld;
  logic [CW-1:0] r_credit;

  logic          w_accept;
  logic          w_pop;
  logic          w_capture;
  logic [31:0]   w_head_dat;
  logic          w_fifo_full;
  logic          w_fifo_empty;

  // Credit covers both in-flight and buffered results, so a full credit means no free buffer slot
  assign in_ready   = ~rst & (r_credit < CW'(DEPTH));
  assign w_accept   = in_valid & in_ready;
  assign out_valid  = ~rst & ~w_fifo_empty;
  assign w_pop      = out_valid & out_ready;
  assign out_result = rst ? '0 : w_head_dat;
  assign busy       = ~rst & (r_credit != '0);
  // Backpressure lives at in_ready, so the pipeline is always advancing outside reset
  assign sprw_holdn = ~rst;

  assign sprw_ra    = r_op.ra;
  assign sprw_rb    = r_op.rb;
  assign sprw_instr = r_op.instr;

  // The valid bit leaving the shift register marks the cycle whose sprw_result belongs to an accepted op
  assign w_capture  = r_vld[LAT-1];

  // Operation register: loads on accept, otherwise holds (bubble cycles leave sprw_* unchanged)
  always_ff @(posedge clk) begin
    if (rst) begin
      r_op <= '0;
    end else if (w_accept) begin
      r_op <= '{ra: in_ra, rb: in_rb, instr: in_instr};
    end
  end

  // Valid tag shift register tracking which pipeline slots carry real operations
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld <= '0;
    end else begin
      r_vld[0] <= w_accept;
      for (int i = 1; i < LAT; i++) begin
        r_vld[i] <= r_vld[i-1];
      end
    end
  end

  // Credit counter: accept takes a credit, pop returns one, both together cancel
  always_ff @(posedge clk) begin
    if (rst) begin
      r_credit <= '0;
    end else begin
      case ({w_accept, w_pop})
        2'b10:   r_credit <= r_credit + 1'b1;
        2'b01:   r_credit <= r_credit - 1'b1;
        default: r_credit <= r_credit;
      endcase
    end
  end

  sprw_result_fifo #(
    .DEPTH (DEPTH),
    .W     (32)
  ) u_result_fifo (
    .clk        (clk),
    .rst        (rst),
    .i_push     (w_capture),
    .i_push_dat (sprw_result),
    .i_pop      (w_pop),
    .o_head_dat (w_head_dat),
    .o_full     (w_fifo_full),
    .o_empty    (w_fifo_empty)
  );

  // A result arriving at a full buffer would be lost; the credit scheme must make this impossible
  a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(w_capture && w_fifo_full && !w_pop));

endmodule

// File: tb/tb_sprw_driver.sv
module tb_sprw_driver;

  localparam int LAT   = 2;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_ra = '0;
  logic [31:0] in_rb = '0;
  logic [31:0] in_instr = '0;
  logic [31:0] sprw_ra;
  logic [31:0] sprw_rb;
  logic [31:0] sprw_instr;
  logic        sprw_holdn;
  logic [31:0] sprw_result;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_result;
  logic        busy;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  logic        rnd_mode = 1'b0;

  sprw_driver #(.LAT(LAT), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_ra(in_ra), .in_rb(in_rb), .in_instr(in_instr),
    .sprw_ra(sprw_ra), .sprw_rb(sprw_rb), .sprw_instr(sprw_instr),
    .sprw_holdn(sprw_holdn), .sprw_result(sprw_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // SPARROW stand-in: op2 == 1 subtracts, anything else adds
  function automatic logic [31:0] alu(input logic [31:0] ra, input logic [31:0] rb, input logic [31:0] instr);
    logic [2:0] op2;
    op2 = instr[14:12];
    return (op2 == 3'd1) ? ra - rb : ra + rb;
  endfunction

  // Pipeline model with LAT-1 register stages (one for LAT=2): result sampled LAT edges after sprw_* load
  logic [31:0] pl_stage;
  always @(posedge clk) pl_stage <= alu(sprw_ra, sprw_rb, sprw_instr);
  assign sprw_result = pl_stage;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every popped result is compared with the head of the expected queue
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got %0h expected nothing at %0t", out_result, $time);
      end else begin
        chk("result", out_result, exp_q.pop_front());
      end
    end
  end

  // Random out_ready driver, active only in the random phase
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rnd_mode) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Present one op starting at posedge+1, wait for accept, push its expected result; returns at posedge+1
  task automatic send(input logic [31:0] ra, input logic [31:0] rb, input logic [31:0] instr,
                      input logic [31:0] exp, output int waits);
    waits = 0;
    in_valid = 1'b1;
    in_ra = ra;
    in_rb = rb;
    in_instr = instr;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      waits++;
      if (waits > 300) break;
    end
    if (waits > 300) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got no accept expected accept within 300 cycles");
    end else begin
      exp_q.push_back(exp);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Wait for all expected results to be popped and the driver idle
  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_done", 32'(n < 2000), 32'd1);
    @(posedge clk);
    #1;
  endtask

  logic [31:0] b2b_v [4][4] = '{
    '{32'd10,  32'd20, 32'h0000_0000, 32'd30},
    '{32'd7,   32'd2,  32'h0000_1000, 32'd5},
    '{32'd100, 32'd1,  32'h7C00_0000, 32'd101},
    '{32'd50,  32'd8,  32'h0000_1000, 32'd42}};
  logic [31:0] bp_v [5][4] = '{
    '{32'd1,    32'd1,  32'h0000_0000, 32'd2},
    '{32'd200,  32'd55, 32'h0000_1000, 32'd145},
    '{32'd3,    32'd4,  32'h0000_0000, 32'd7},
    '{32'd1000, 32'd1,  32'h0000_1000, 32'd999},
    '{32'd12,   32'd34, 32'h0000_0000, 32'd46}};

  initial begin
    int w;
    int wsum;
    logic [31:0] ra, rb, ins;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_holdn", 32'(sprw_holdn), 0);
    chk("rst_sprw_ra", sprw_ra, 0);
    chk("rst_out_result", out_result, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", 32'(in_ready), 1);
    chk("post_rst_holdn", 32'(sprw_holdn), 1);
    @(posedge clk);
    #1;

    // Single op: 5 + 3 = 8, visible at edge t+3
    send(32'd5, 32'd3, 32'd0, 32'd8, w);
    chk("single_wait", 32'(w), 0);
    @(negedge clk);
    chk("single_sprw_ra", sprw_ra, 32'd5);
    chk("single_lat_t0", 32'(out_valid), 0);
    @(negedge clk);
    chk("single_lat_t1", 32'(out_valid), 0);
    @(negedge clk);
    chk("single_lat_t2", 32'(out_valid), 1);
    chk("single_busy_before", 32'(busy), 1);
    @(negedge clk);
    chk("single_busy_after", 32'(busy), 0);
    chk("single_empty_after", 32'(out_valid), 0);
    @(posedge clk);
    #1;

    // Back-to-back: four accepts on consecutive cycles, results without bubbles
    wsum = 0;
    for (int k = 0; k < 4; k++) begin
      send(b2b_v[k][0], b2b_v[k][1], b2b_v[k][2], b2b_v[k][3], w);
      wsum += w;
    end
    chk("b2b_no_stall", 32'(wsum), 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("b2b_no_bubble", 32'(out_valid), 1);
    end
    @(negedge clk);
    chk("b2b_empty_after", 32'(out_valid), 0);
    @(posedge clk);
    #1;
    drain();

    // Backpressure: four accepted, fifth held until one pop, then accepted the following cycle
    out_ready = 1'b0;
    wsum = 0;
    for (int k = 0; k < 4; k++) begin
      send(bp_v[k][0], bp_v[k][1], bp_v[k][2], bp_v[k][3], w);
      wsum += w;
    end
    chk("bp_first4_no_stall", 32'(wsum), 0);
    in_valid = 1'b1;
    in_ra = bp_v[4][0];
    in_rb = bp_v[4][1];
    in_instr = bp_v[4][2];
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("bp_full_in_ready", 32'(in_ready), 0);
    end
    chk("bp_full_busy", 32'(busy), 1);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_pop_same_cycle", 32'(in_ready), 0);
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk("bp_pop_next_cycle", 32'(in_ready), 1);
    exp_q.push_back(bp_v[4][3]);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    drain();

    // Full credit, then streaming accepts with pops: credit conserved, order kept across pointer wrap
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) send(32'(k * 16 + 1), 32'(k), 32'd0, 32'(k * 17 + 1), w);
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    wsum = 0;
    for (int k = 4; k < 16; k++) begin
      send(32'(k * 16 + 1), 32'(k), 32'd0, 32'(k * 17 + 1), w);
      wsum += w;
    end
    chk("wrap_single_stall", 32'(wsum), 1);
    drain();

    // Reset with three ops in flight/buffered: all discarded
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) send(32'(k + 1), 32'd1, 32'd0, 32'(k + 2), w);
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    chk("mid_rst_out_valid", 32'(out_valid), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_in_ready", 32'(in_ready), 0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("post_rst_no_stale", 32'(out_valid), 0);
    end
    chk("post_rst_busy", 32'(busy), 0);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(32'd40, 32'd2, 32'h0000_1000, 32'd38, w);
    drain();

    // Random valid/ready over 1000 ops against the expected queue
    rnd_mode = 1'b1;
    for (int k = 0; k < 1000; k++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      ra = $urandom;
      rb = $urandom;
      ins = ($urandom & 32'hFFFF_8FFF) | (($urandom_range(0, 1) == 1) ? 32'h0000_1000 : 32'h0);
      send(ra, rb, ins, alu(ra, rb, ins), w);
    end
    rnd_mode = 1'b0;
    out_ready = 1'b1;
    drain();
    chk("final_queue_empty", 32'(exp_q.size()), 0);
    chk("final_idle", 32'(busy), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Watchdog: the run always ends with a summary
  initial begin
    #400000;
    errors++;
    $display("FAIL watchdog: got no completion expected completion within 40000 cycles");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
